// File: rtl/decode_fetch_queue.sv
// decode_fetch_queue
// DEPTH-entry instruction queue that sits between fetch and decode.
// Each entry holds {instruction, pc_plus_four}. Fetch keeps pushing while
// decode is stalled. A flush (taken branch or jump) squashes every queued
// entry. Decode sees an explicit valid bit and a NOP (all zeros) whenever
// the queue is empty.
// Storage is not reset: entries are only visible while they are counted
// as valid, so stale contents never reach decode.

module decode_fetch_queue #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 4,
    parameter int PTR_WIDTH   = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   fetch_valid,
    input  logic [INSTR_WIDTH-1:0] fetch_instruction,
    input  logic [PC_WIDTH-1:0]    fetch_pc_plus_four,
    output logic                   fetch_ready,
    input  logic                   decode_ready,
    output logic                   decode_valid,
    output logic [INSTR_WIDTH-1:0] decode_instruction,
    output logic [PC_WIDTH-1:0]    decode_pc_plus_four,
    input  logic                   flush,
    output logic [PTR_WIDTH:0]     occupancy,
    output logic [CNT_WIDTH-1:0]   flush_count
);

    // Occupancy value that means "full"; occupancy is one bit wider than
    // the pointers so that DEPTH itself is representable.
    localparam logic [PTR_WIDTH:0]   DEPTH_C   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   COUNT_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] FLUSH_ONE = CNT_WIDTH'(1);

    // Entry storage, split into two arrays for clarity.
    logic [INSTR_WIDTH-1:0] mem_instr_r [DEPTH];
    logic [PC_WIDTH-1:0]    mem_pc_r    [DEPTH];

    // Queue state.
    logic [PTR_WIDTH-1:0]   rd_ptr_r;
    logic [PTR_WIDTH-1:0]   wr_ptr_r;
    logic [PTR_WIDTH:0]     count_r;
    logic [CNT_WIDTH-1:0]   flush_count_r;

    // Next-state values.
    logic [PTR_WIDTH-1:0]   rd_ptr_next_s;
    logic [PTR_WIDTH-1:0]   wr_ptr_next_s;
    logic [PTR_WIDTH:0]     count_next_s;
    logic [CNT_WIDTH-1:0]   flush_count_next_s;

    // Handshake qualifiers.
    logic                   not_empty_s;
    logic                   not_full_s;
    logic                   push_s;
    logic                   pop_s;

    // Status flags come straight from the registered count, so fetch_ready
    // never depends on decode_ready in the same cycle.
    assign not_empty_s = (count_r != {(PTR_WIDTH+1){1'b0}});
    assign not_full_s  = (count_r != DEPTH_C);

    // A push needs room; a pop needs a valid head. Both are squashed by
    // flush inside the next-state logic.
    assign push_s = fetch_valid & not_full_s;
    assign pop_s  = not_empty_s & decode_ready;

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        if (flush) begin
            rd_ptr_next_s = {PTR_WIDTH{1'b0}};
            wr_ptr_next_s = {PTR_WIDTH{1'b0}};
            count_next_s  = {(PTR_WIDTH+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + COUNT_ONE;
                2'b01:   count_next_s = count_r - COUNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next value of the saturating flush counter.
    always_comb begin
        flush_count_next_s = flush_count_r;
        if (flush && (flush_count_r != FLUSH_MAX)) begin
            flush_count_next_s = flush_count_r + FLUSH_ONE;
        end else begin
            flush_count_next_s = flush_count_r;
        end
    end

    // Pointer, occupancy and flush-counter registers with async reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r      <= {PTR_WIDTH{1'b0}};
            wr_ptr_r      <= {PTR_WIDTH{1'b0}};
            count_r       <= {(PTR_WIDTH+1){1'b0}};
            flush_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            rd_ptr_r      <= rd_ptr_next_s;
            wr_ptr_r      <= wr_ptr_next_s;
            count_r       <= count_next_s;
            flush_count_r <= flush_count_next_s;
        end
    end

    // Entry write; a push in a flush cycle is discarded so nothing is stored.
    always_ff @(posedge clock) begin
        if (push_s && !flush) begin
            mem_instr_r[wr_ptr_r] <= fetch_instruction;
            mem_pc_r[wr_ptr_r]    <= fetch_pc_plus_four;
        end
    end

    // Output mapping: head entry is read combinationally and masked to a NOP
    // when the queue is empty.
    assign fetch_ready         = not_full_s;
    assign decode_valid        = not_empty_s;
    assign occupancy           = count_r;
    assign flush_count         = flush_count_r;
    assign decode_instruction  = not_empty_s ? mem_instr_r[rd_ptr_r] : {INSTR_WIDTH{1'b0}};
    assign decode_pc_plus_four = not_empty_s ? mem_pc_r[rd_ptr_r]    : {PC_WIDTH{1'b0}};

endmodule
